dffram_bw_clr: RTL



---
 rtl/dffram_bw_clr.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dffram_bw_clr.sv
// Single-port byte-write RAM that zeroes every word after reset before accepting accesses.
// Optional per-byte even parity storage and checking is enabled by defining RAM_PARITY_EN.
module dffram_bw_clr #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 64,
   localparam int AW    = $clog2(DEPTH),
   localparam int NB    = WIDTH / 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             EN0,
   input  logic [NB-1:0]    WE0,
   input  logic [AW-1:0]    A0,
   input  logic [WIDTH-1:0] Di0,
   output logic [WIDTH-1:0] Do0,
   output logic             BUSY,
   output logic             VALID,
   output logic             PERR
);

`ifdef RAM_PARITY_EN
   localparam int MW = WIDTH + NB;
`else
   localparam int MW = WIDTH;
`endif

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [AW-1:0]   clr_q;
   logic [AW-1:0]   clr_d;
   logic            clr_we;
   logic            acc;

   logic [MW-1:0]   mem [DEPTH];
   logic [MW-1:0]   rd_word;
   logic [MW-1:0]   wr_word;

   // Access contract: an access is accepted at a rising edge when EN0=1 and
   // BUSY=0; its read data (old contents) appears on Do0 with VALID=1 one
   // cycle later. There is no backpressure, so accesses may arrive every cycle.
   assign BUSY = (state_q == ST_CLEAR);
   assign acc  = EN0 && !BUSY;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_CLEAR;
         clr_q   <= '0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      clr_d   = clr_q;
      clr_we  = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            clr_we = 1'b1;
            clr_d  = clr_q + 1'b1;
            if (clr_q == LAST_ADDR) begin
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            state_d = ST_READY;
         end
         default: begin
            state_d = ST_CLEAR;
         end
      endcase
   end

   assign rd_word = mem[A0];

   // Merge enabled byte lanes into the old word so one full-word write suffices.
   always_comb begin
      wr_word = rd_word;
      for (int i = 0; i < NB; i++) begin
         if (WE0[i]) begin
            wr_word[8*i +: 8] = Di0[8*i +: 8];
`ifdef RAM_PARITY_EN
            wr_word[WIDTH + i] = ^Di0[8*i +: 8];
`endif
         end
      end
   end

   // The array itself has no reset; the clear sequencer provides known contents.
   always_ff @(posedge CLK) begin
      if (clr_we) begin
         mem[clr_q] <= '0;
      end else if (acc && (|WE0)) begin
         mem[A0] <= wr_word;
      end
   end

`ifdef RAM_PARITY_EN
   logic lane_err;
   logic perr_q;

   always_comb begin
      lane_err = 1'b0;
      for (int i = 0; i < NB; i++) begin
         lane_err = lane_err | (rd_word[WIDTH + i] ^ (^rd_word[8*i +: 8]));
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         perr_q <= 1'b0;
      end else begin
         perr_q <= acc && lane_err;
      end
   end

   assign PERR = perr_q;
`else
   assign PERR = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         Do0   <= '0;
         VALID <= 1'b0;
      end else begin
         Do0   <= acc ? rd_word[WIDTH-1:0] : '0;
         VALID <= acc;
      end
   end

endmodule
